// File: rtl/mult_unit_pkg.sv
// Shared CPU definitions used by the multiply unit.
// FSM encodings and the default operand width.
package mult_unit_pkg;

  localparam int DEF_SIZE = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_unit_twos_neg.sv
// Combinational two's-complement negate.
// Used for operand magnitudes and product sign correction.
module twos_neg #(
  parameter int width = 32
) (
  input  logic [width-1:0] a,
  output logic [width-1:0] y
);

  assign y = ~a + {{(width-1){1'b0}}, 1'b1};

endmodule

// File: rtl/mult_unit.sv
// Sequential shift-add multiplier producing a HI/LO product.
// One iteration per cycle; sign applied to magnitudes at the end.
module mult_unit
  import mult_unit_pkg::*;
#(
  parameter int size = DEF_SIZE
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            signed_i,
  input  logic [size-1:0] src1_i,
  input  logic [size-1:0] src2_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [size-1:0] hi_o,
  output logic [size-1:0] lo_o
);

  localparam int CW = (size > 1) ? $clog2(size) : 1;
  localparam logic [CW-1:0] LAST = CW'(size - 1);

  state_t          state;
  logic [size-1:0] mcand;
  logic [size-1:0] mplier;
  logic            neg;
  logic [2*size-1:0] acc;
  logic [CW-1:0]   cnt;

  logic [size-1:0] src1_neg, src2_neg;
  logic [size-1:0] src1_mag, src2_mag;
  logic [size:0]   sum;
  logic [2*size-1:0] acc_next, acc_neg, result;
  logic            unused_lsb;

  twos_neg #(.width(size)) u_neg1 (
    .a(src1_i),
    .y(src1_neg)
  );

  twos_neg #(.width(size)) u_neg2 (
    .a(src2_i),
    .y(src2_neg)
  );

  assign src1_mag = (signed_i && src1_i[size-1]) ? src1_neg : src1_i;
  assign src2_mag = (signed_i && src2_i[size-1]) ? src2_neg : src2_i;

  // Add into the upper half, then shift the whole accumulator right.
  // The bit shifted out is always zero within size iterations.
  assign sum = {1'b0, acc[2*size-1:size]}
             + {1'b0, mcand & {size{mplier[cnt]}}};
  assign acc_next = {sum, acc[size-1:1]};
  assign unused_lsb = acc[0];

  twos_neg #(.width(2*size)) u_neg_res (
    .a(acc_next),
    .y(acc_neg)
  );

  assign result = neg ? acc_neg : acc_next;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      hi_o   <= '0;
      lo_o   <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_o <= 1'b0;
          if (start_i) begin
            mcand  <= src1_mag;
            mplier <= src2_mag;
            neg    <= signed_i & (src1_i[size-1] ^ src2_i[size-1]);
            acc    <= '0;
            cnt    <= '0;
            busy_o <= 1'b1;
            state  <= CALC;
          end else begin
            state  <= IDLE;
          end
        end
        CALC: begin
          acc <= acc_next;
          if (cnt == LAST) begin
            {hi_o, lo_o} <= result;
            cnt    <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state  <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          busy_o <= 1'b0;
          done_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_unit.sv
// Scoreboard bench for mult_unit: stimulus pushes expected products,
// a negedge monitor pops and compares on every done pulse.
module tb_mult_unit;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           cyc;
  } exp_t;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         start_i = 1'b0;
  logic         signed_i = 1'b0;
  logic [W-1:0] src1_i = '0;
  logic [W-1:0] src2_i = '0;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  mult_unit #(.size(W)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .signed_i(signed_i),
    .src1_i  (src1_i),
    .src2_i  (src2_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Monitor: every done pulse must match the oldest expected product.
  always @(negedge clk_i) begin
    if (!rst_i && done_o) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done cyc=%0d hi=%h lo=%h", cyc, hi_o, lo_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (hi_o !== e.hi || lo_o !== e.lo || cyc != e.cyc || busy_o !== 1'b0) begin
          n_err++;
          $display("FAIL product got hi=%h lo=%h cyc=%0d busy=%b want hi=%h lo=%h cyc=%0d busy=0",
                   hi_o, lo_o, cyc, busy_o, e.hi, e.lo, e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] got,
                       input logic [W-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Issue one multiply; s is the edge count at which start was sampled.
  task automatic issue(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eh, input logic [W-1:0] el,
                       input bit push, output int s);
    @(negedge clk_i);
    start_i  = 1'b1;
    signed_i = sg;
    src1_i   = a;
    src2_i   = b;
    @(posedge clk_i);
    #1;
    s = cyc;
    if (push) sb.push_back('{eh, el, s + 32});
    start_i = 1'b0;
  endtask

  task automatic run(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] eh, input logic [W-1:0] el);
    int s;
    issue(sg, a, b, eh, el, 1'b1, s);
    repeat (33) @(posedge clk_i);
  endtask

  initial begin
    int s;
    int bad;

    repeat (3) @(negedge clk_i);
    check("reset_busy", {31'd0, busy_o}, 32'd0);
    check("reset_done", {31'd0, done_o}, 32'd0);
    check("reset_hi", hi_o, 32'd0);
    check("reset_lo", lo_o, 32'd0);
    rst_i = 1'b0;

    // 3 x 5 with busy window check
    issue(1'b0, 32'd3, 32'd5, 32'h0, 32'hF, 1'b1, s);
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk_i);
      if (busy_o !== 1'b1) bad++;
    end
    check("busy_window_errs", bad, 32'd0);
    @(negedge clk_i);
    check("busy_after", {31'd0, busy_o}, 32'd0);
    repeat (2) @(posedge clk_i);

    run(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run(1'b1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA);
    run(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);
    run(1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run(1'b1, 32'h80000000, 32'd1,        32'hFFFFFFFF, 32'h80000000);
    run(1'b0, 32'h80000000, 32'd2,        32'h00000001, 32'h00000000);
    run(1'b1, 32'd5,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run(1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001);
    run(1'b0, 32'h12345678, 32'd0,        32'h00000000, 32'h00000000);
    run(1'b0, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE);

    // 7 x 9, ignored start mid-CALC, then back-to-back 3 x 4 from DONE
    issue(1'b0, 32'd7, 32'd9, 32'h0, 32'd63, 1'b1, s);
    repeat (4) @(negedge clk_i);
    start_i = 1'b1;
    src1_i  = 32'd2;
    src2_i  = 32'd2;
    repeat (3) @(negedge clk_i);
    start_i = 1'b0;
    while (cyc < s + 32) @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b1;
    src1_i  = 32'd3;
    src2_i  = 32'd4;
    @(posedge clk_i);
    #1;
    sb.push_back('{32'h0, 32'd12, cyc + 32});
    start_i = 1'b0;
    repeat (33) @(posedge clk_i);

    // 6 x 7 aborted by reset mid-CALC
    issue(1'b0, 32'd6, 32'd7, 32'h0, 32'h0, 1'b0, s);
    repeat (9) @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_hi", hi_o, 32'd0);
    check("rst_lo", lo_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    run(1'b0, 32'd4, 32'd4, 32'h0, 32'd16);

    bad = 0;
    while (sb.size() != 0 && bad < 100) begin
      @(posedge clk_i);
      bad++;
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout pending=%0d want=0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
